// File: rtl/hazard_control_unit.sv
// Hazard sequencer between IF/ID and ID/EX: load-use stalls, redirect
// flushes, data-memory freezes, and saturating stall/flush counters.
module hazard_control_unit #(
    parameter int LOAD_USE_STALLS = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exMemReadIn,
    input  logic [4:0]             exRtIn,
    input  logic [4:0]             idRsIn,
    input  logic [4:0]             idRtIn,
    input  logic                   idUsesRtIn,
    input  logic                   exRedirectIn,
    input  logic                   memWaitIn,
    output logic                   pcWriteOut,
    output logic                   ifIdWriteOut,
    output logic                   ifIdFlushOut,
    output logic                   idExBubbleOut,
    output logic                   idExHoldOut,
    output logic [COUNT_WIDTH-1:0] stallCountOut,
    output logic [COUNT_WIDTH-1:0] flushCountOut
);

    typedef enum logic [1:0] {
        NORMAL,
        LU_STALL,
        WAIT
    } state_t;

    localparam logic [2:0] EXTRA = 3'(LOAD_USE_STALLS - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     stateNext;
    state_t     effState;
    logic [2:0] remaining;
    logic [2:0] remainingNext;
    logic       loadUse;
    logic       redirectApplied;

    assign loadUse = exMemReadIn && (exRtIn != 5'd0) &&
                     ((exRtIn == idRsIn) ||
                      (idUsesRtIn && (exRtIn == idRtIn)));

    // Leaving WAIT behaves exactly like the state it resumes into.
    always_comb begin
        effState = state;
        if (state == WAIT) begin
            effState = (remaining != 3'd0) ? LU_STALL : NORMAL;
        end
    end

    always_comb begin
        pcWriteOut      = 1'b1;
        ifIdWriteOut    = 1'b1;
        ifIdFlushOut    = 1'b0;
        idExBubbleOut   = 1'b0;
        idExHoldOut     = 1'b0;
        redirectApplied = 1'b0;
        stateNext       = effState;
        remainingNext   = remaining;
        if (rst) begin
            pcWriteOut    = 1'b0;
            ifIdWriteOut  = 1'b0;
            ifIdFlushOut  = 1'b1;
            idExBubbleOut = 1'b1;
            stateNext     = NORMAL;
            remainingNext = 3'd0;
        end else if (memWaitIn) begin
            pcWriteOut   = 1'b0;
            ifIdWriteOut = 1'b0;
            idExHoldOut  = 1'b1;
            stateNext    = WAIT;
        end else if (exRedirectIn) begin
            ifIdFlushOut    = 1'b1;
            idExBubbleOut   = 1'b1;
            redirectApplied = 1'b1;
            stateNext       = NORMAL;
            remainingNext   = 3'd0;
        end else begin
            unique case (effState)
                LU_STALL: begin
                    pcWriteOut    = 1'b0;
                    ifIdWriteOut  = 1'b0;
                    idExBubbleOut = 1'b1;
                    remainingNext = remaining - 3'd1;
                    stateNext     = (remaining == 3'd1) ? NORMAL : LU_STALL;
                end
                default: begin
                    stateNext = NORMAL;
                    if (loadUse) begin
                        pcWriteOut    = 1'b0;
                        ifIdWriteOut  = 1'b0;
                        idExBubbleOut = 1'b1;
                        if (EXTRA != 3'd0) begin
                            remainingNext = EXTRA;
                            stateNext     = LU_STALL;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= NORMAL;
            remaining     <= 3'd0;
            stallCountOut <= '0;
            flushCountOut <= '0;
        end else begin
            state     <= stateNext;
            remaining <= remainingNext;
            if (!pcWriteOut && stallCountOut != CNT_MAX) begin
                stallCountOut <= stallCountOut + 1'b1;
            end
            if (redirectApplied && flushCountOut != CNT_MAX) begin
                flushCountOut <= flushCountOut + 1'b1;
            end
        end
    end

endmodule
